// File: rtl/pipe_ctrl.sv
// Decode-stage acceptance and EX/MEM/WB control pipeline for a simple in-order core.
// Handles load-use stalls, branch flushes and a sticky halt that lets older work drain.
module pipe_ctrl #(
  parameter int             IW     = 16,
  parameter int             OPW    = 4,
  parameter int             RW     = 4,
  parameter logic [OPW-1:0] OP_LW  = 4'b1000,
  parameter logic [OPW-1:0] OP_SW  = 4'b1001,
  parameter logic [OPW-1:0] OP_B   = 4'b1100,
  parameter logic [OPW-1:0] OP_BR  = 4'b1101,
  parameter logic [OPW-1:0] OP_HLT = 4'b1111
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IW-1:0]  instr,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic           flush,
  output logic           ex_valid,
  output logic [OPW-1:0] ex_opcode,
  output logic           mem_valid,
  output logic           mem_en,
  output logic           mem_wr,
  output logic           wb_valid,
  output logic [RW-1:0]  wb_dst,
  output logic           wb_we,
  output logic           hazard,
  output logic           halted
);

  // Handshake: instr is consumed on a rising edge where instr_valid & instr_ready;
  // otherwise the upstream must hold instr stable and EX takes a bubble.
  logic [OPW-1:0] w_op;
  logic [RW-1:0]  w_dst;
  logic [RW-1:0]  w_src1;
  logic [RW-1:0]  w_src2;
  logic           w_mem_en;
  logic           w_mem_wr;
  logic           w_we;
  logic           w_is_load;
  logic           w_is_hlt;
  logic           w_accept;

  logic           r_ex_valid;
  logic [OPW-1:0] r_ex_opcode;
  logic [RW-1:0]  r_ex_dst;
  logic           r_ex_mem_en;
  logic           r_ex_mem_wr;
  logic           r_ex_we;
  logic           r_ex_is_load;
  logic           r_ex_is_hlt;

  logic           r_mem_valid;
  logic [RW-1:0]  r_mem_dst;
  logic           r_mem_en;
  logic           r_mem_wr;
  logic           r_mem_we;
  logic           r_mem_is_hlt;

  logic           r_wb_valid;
  logic [RW-1:0]  r_wb_dst;
  logic           r_wb_we;
  logic           r_wb_is_hlt;

  logic           r_halt_seen;
  logic           r_halted;

  assign w_op      = instr[IW-1 -: OPW];
  assign w_dst     = instr[IW-OPW-1 -: RW];
  assign w_src1    = instr[IW-OPW-RW-1 -: RW];
  assign w_src2    = instr[IW-OPW-2*RW-1 -: RW];

  assign w_mem_en  = (w_op == OP_LW) || (w_op == OP_SW);
  assign w_mem_wr  = (w_op == OP_SW);
  assign w_we      = !((w_op == OP_SW) || (w_op == OP_B) || (w_op == OP_BR) || (w_op == OP_HLT));
  assign w_is_load = (w_op == OP_LW);
  assign w_is_hlt  = (w_op == OP_HLT);

  // A write to r0 is architecturally discarded, so it never creates a dependency.
  assign hazard      = instr_valid & r_ex_valid & r_ex_is_load & (r_ex_dst != '0) &
                       ((r_ex_dst == w_src1) | (r_ex_dst == w_src2));
  assign instr_ready = ~hazard & ~r_halt_seen & ~flush;
  assign w_accept    = instr_valid & instr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_opcode  <= '0;
      r_ex_dst     <= '0;
      r_ex_mem_en  <= 1'b0;
      r_ex_mem_wr  <= 1'b0;
      r_ex_we      <= 1'b0;
      r_ex_is_load <= 1'b0;
      r_ex_is_hlt  <= 1'b0;
    end else begin
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_ex_opcode  <= w_op;
        r_ex_dst     <= w_dst;
        r_ex_mem_en  <= w_mem_en;
        r_ex_mem_wr  <= w_mem_wr;
        r_ex_we      <= w_we;
        r_ex_is_load <= w_is_load;
        r_ex_is_hlt  <= w_is_hlt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_valid  <= 1'b0;
      r_mem_dst    <= '0;
      r_mem_en     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_is_hlt <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wb_dst     <= '0;
      r_wb_we      <= 1'b0;
      r_wb_is_hlt  <= 1'b0;
    end else begin
      r_mem_valid  <= r_ex_valid;
      r_mem_dst    <= r_ex_dst;
      r_mem_en     <= r_ex_mem_en;
      r_mem_wr     <= r_ex_mem_wr;
      r_mem_we     <= r_ex_we;
      r_mem_is_hlt <= r_ex_is_hlt;
      r_wb_valid   <= r_mem_valid;
      r_wb_dst     <= r_mem_dst;
      r_wb_we      <= r_mem_we;
      r_wb_is_hlt  <= r_mem_is_hlt;
    end
  end

  // halt_seen blocks new work at acceptance; halted reports retirement one cycle after WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_halt_seen <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      if (w_accept && w_is_hlt) r_halt_seen <= 1'b1;
      if (r_wb_valid && r_wb_is_hlt) r_halted <= 1'b1;
    end
  end

  assign ex_valid  = r_ex_valid;
  assign ex_opcode = r_ex_opcode;
  assign mem_valid = r_mem_valid;
  assign mem_en    = r_mem_valid & r_mem_en;
  assign mem_wr    = r_mem_valid & r_mem_wr;
  assign wb_valid  = r_wb_valid;
  assign wb_dst    = r_wb_dst;
  assign wb_we     = r_wb_valid & r_wb_we;
  assign halted    = r_halted;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter IW, default 16: instruction width; SHALL be >= OPW + 3*RW.
REQ-002 Parameter OPW, default 4: opcode width; opcode = instr[IW-1 -: OPW].
REQ-003 Parameter RW, default 4: register-address width; dst = instr[IW-OPW-1 -: RW], src1 = next RW bits, src2 = next RW bits.
REQ-004 Parameter OP_LW, default 4'b1000; OP_SW, default 4'b1001; OP_B, default 4'b1100; OP_BR, default 4'b1101; OP_HLT, default 4'b1111: decode opcodes.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low.
REQ-007 instr  input  IW  decode-stage instruction.
REQ-008 instr_valid  input  1  instr is valid this cycle.
REQ-009 instr_ready  output  1  instr is accepted this cycle when instr_valid & instr_ready.
REQ-010 flush  input  1  kill the decode-stage instruction (branch taken).
REQ-011 ex_valid, ex_opcode  output  1, OPW  EX-stage control.
REQ-012 mem_valid, mem_en, mem_wr  output  1,1,1  MEM-stage control.
REQ-013 wb_valid, wb_dst, wb_we  output  1, RW, 1  WB-stage control.
REQ-014 hazard  output  1  load-use stall indication.
REQ-015 halted  output  1  sticky; a halt has retired from WB.

Function
REQ-016 Decode SHALL give: mem_en = opcode is OP_LW or OP_SW; mem_wr = opcode is OP_SW; we = 0 for OP_SW, OP_B, OP_BR, OP_HLT, else 1; is_load = opcode is OP_LW.
REQ-017 Control SHALL advance as a 3-stage shift register EX -> MEM -> WB, one stage per cycle, with no back-pressure between stages.
REQ-018 An accepted instruction at cycle N SHALL appear with ex_valid=1 at N+1, mem_valid=1 at N+2, wb_valid=1 at N+3.
REQ-019 mem_en, mem_wr, wb_we SHALL be forced to 0 when the corresponding stage valid is 0; ex_opcode/wb_dst hold don't-care-but-registered values.
REQ-020 hazard SHALL be combinational: instr_valid & ex_valid & ex_is_load & (ex_dst != 0) & (ex_dst == src1 | ex_dst == src2).
REQ-021 instr_ready SHALL equal ~hazard & ~halt_seen & ~flush.
REQ-022 When instr_valid & ~instr_ready, EX SHALL load a bubble (ex_valid=0); the upstream holds instr.
REQ-023 flush SHALL take precedence over hazard: EX loads a bubble; instructions already in EX/MEM/WB are unaffected.
REQ-024 halt_seen (internal) SHALL set when an OP_HLT instruction is accepted; no further instructions are accepted until reset.
REQ-025 halted SHALL set in the cycle after OP_HLT is in WB with wb_valid=1, and remain 1 until reset.
REQ-026 Stages behind a halt SHALL drain normally, then hold bubbles.

Reset
REQ-027 While rst=0 all stage valids, mem_en, mem_wr, wb_we, halted, halt_seen SHALL be 0; ex_opcode, wb_dst SHALL be 0.
REQ-028 Reset assertion mid-operation SHALL discard every in-flight instruction immediately (asynchronous); the first acceptance is possible in the first clk edge after rst returns to 1.

Verification
REQ-029 ADD r1 (opcode 0000, dst 1) accepted at cycle 0 -> ex_valid@1, mem_valid@2 with mem_en=0, wb_valid@3 with wb_dst=1, wb_we=1.
REQ-030 LW r2 at cycle 0, then at cycle 1 an instruction with src1=2 -> hazard=1, instr_ready=0 at cycle 1, bubble in EX@2, instruction accepted at cycle 2, reaches WB@5.
REQ-031 LW r0 followed by an instruction with src1=0 -> hazard=0, no stall.
REQ-032 SW at cycle 0 -> mem_en=1, mem_wr=1 at cycle 2; wb_we=0 at cycle 3; flush at cycle 1 with LW presented -> ex_valid=0 at 2, SW unaffected.
REQ-033 HLT accepted at cycle 0, valid instructions presented after -> instr_ready=0 from cycle 1, wb_valid@3, halted=1 from cycle 4 onward.
REQ-034 rst pulled low while LW is in MEM -> mem_en=0, all valids=0 immediately; after release, ADD is accepted on the first edge.
